apb_rsp_collector: RTL
======================

# apb_rsp_collector

Passive APB observer on the return path of the file-to-bus chain. It watches the shared APB bus between the APB master and its slaves and detects each completed transfer. Each completed read is packed, with an optional write log, into the same 22-bit word format the file reader produces. The words are buffered and offered downstream on a valid/ready stream, for a file writer or scoreboard, so bus results can be dumped and compared against the input file.

## Interface

Parameters:
- DEPTH, 8, buffer entries (power of two, 2..64)
- CNT_W, 4, width of `count` (log2(DEPTH)+1)

Ports:
- pclk  in  1  clock; all logic on rising edge
- prst  in  1  reset, synchronous, active-high
- psel1  in  1  slave 1 select
- psel2  in  1  slave 2 select
- psel3  in  1  slave 3 select
- psel4  in  1  slave 4 select
- penable  in  1  APB access phase
- pwrite  in  1  transfer direction (1 = write)
- pready  in  1  slave ready
- paddr  in  4  transfer address
- pwdata  in  16  write data
- prdata  in  16  read data
- log_writes  in  1  1 = also capture write transfers
- m_ready  in  1  downstream accepts head word
- clr_err  in  1  clears `overflow`, `proto_err`, `drop_cnt`
- m_valid  out  1  head word valid
- m_data  out  22  {addr[21:18], data[17:2], slave_idx[1:0]}
- count  out  CNT_W  entries held
- overflow  out  1  sticky: a completion was dropped while full
- proto_err  out  1  sticky: illegal APB sequence seen
- drop_cnt  out  8  dropped completions, saturating at 255

## Operation

- Phase tracker FSM, registered, one of IDLE / SETUP / ACCESS.
  - any_sel = psel1|psel2|psel3|psel4.
  - Next state is IDLE if !any_sel.
  - Next state is SETUP if any_sel & !penable.
  - Next state is ACCESS if any_sel & penable.
- Completion is a cycle with all of the following:
  - exactly one psel high;
  - penable=1 and pready=1;
  - tracker state (previous cycle) is SETUP or ACCESS.
- Protocol errors set `proto_err` and are not captured:
  - more than one psel high in any cycle;
  - penable=1 with any_sel while the state is IDLE, i.e. no setup phase;
  - penable=1 with !any_sel.
- Captured word:
  - addr = paddr;
  - slave_idx = 0/1/2/3 for psel1/2/3/4;
  - data = prdata if pwrite=0, otherwise pwdata.
  - A write completion is captured only when log_writes=1; otherwise it is ignored silently, with no drop counted.
- Buffer is a circular FIFO of DEPTH entries with write pointer, read pointer and count.
  - `m_data` shows the head entry (first-word-fall-through).
  - `m_valid` = (count != 0).
- Pop happens when m_valid & m_ready.
- Push and pop in the same cycle: both happen and count is unchanged. This applies when full, so a push while full with a simultaneous pop is accepted.
- Push while full without pop: the word is dropped, `overflow` is set, and `drop_cnt` is incremented, saturating at 255.
- Pointers wrap modulo DEPTH.
- `clr_err` has priority over a same-cycle set: a new error in the clr_err cycle is lost.

## Timing

- Reset (prst=1 at a clock edge):
  - FSM goes to IDLE;
  - pointers and count go to 0, so m_valid=0;
  - overflow=0, proto_err=0, drop_cnt=0;
  - m_data=0 (storage is cleared).
- Reset mid-operation flushes all buffered words. Reset overrides push, pop and clr_err in the same cycle.
- Latency:
  - A completion at edge N appears on m_valid/m_data after edge N, i.e. visible in cycle N+1.
  - When empty, a word cannot be popped in its capture cycle.
- Pop at edge N: the next head is visible in cycle N+1. Sustained throughput is 1 word/cycle.
- Wait states (pready=0 in ACCESS) keep the state at ACCESS, and nothing is captured until pready=1.
- Back-to-back transfers follow SETUP→ACCESS→SETUP with no IDLE between; each completion is captured.
- Sticky flags and drop_cnt update at the edge of the offending cycle.

## Test plan

- Read completion: SETUP psel2/paddr=4'h3, then ACCESS with pready=1, prdata=16'hBEEF, pwrite=0 → next cycle m_valid=1, m_data={4'h3,16'hBEEF,2'd1}, count=1; m_ready=1 → count=0 the following cycle.
- Wait states and writes: ACCESS held 3 cycles with pready=0, then pready=1, psel4, pwrite=1, pwdata=16'h1234, log_writes=1 → exactly one word {paddr,16'h1234,2'd3}. Repeating the same transfer with log_writes=0 → no word, drop_cnt=0.
- Overflow: DEPTH=8, m_ready=0, 10 read completions → count=8, overflow=1, drop_cnt=2, words 0..7 in order. Then a completion with m_ready=1 → push accepted, count stays 8.
- Protocol errors: penable=1 with psel1 straight from IDLE → proto_err=1, count unchanged. psel1 and psel3 both high → proto_err. clr_err=1 → proto_err=0, drop_cnt=0.
- Wrap and streaming: 20 completions with m_ready=1 every cycle → all 20 words out in order with no drops, and count never exceeds 2.
- Reset mid-stream: count=5, prst=1 for 1 cycle → m_valid=0, count=0, flags 0. The next completion is captured normally.

Source files
------------

// File: rtl/apb_rsp_collector.sv
// rtl/apb_rsp_collector.sv - passive APB observer packing completed transfers into a stream FIFO
//
// Purpose:
//   Watches a shared APB bus (up to four slaves), tracks the transfer phase,
//   detects completed transfers and packs each captured one into a 22-bit word
//   {addr[21:18], data[17:2], slave_idx[1:0]}. Words are held in a
//   first-word-fall-through circular buffer and offered on a valid/ready stream.
//   Illegal bus sequences and buffer overruns are reported through sticky flags.
//
// Ports:
//   pclk, prst               clock, synchronous active-high reset
//   psel1..psel4             slave selects
//   penable, pwrite, pready  APB phase, direction, slave ready
//   paddr, pwdata, prdata    APB address and data buses
//   log_writes               1 = capture write transfers as well as reads
//   m_ready                  downstream accepts the head word
//   clr_err                  clears overflow, proto_err and drop_cnt
//   m_valid, m_data          head word of the buffer
//   count                    number of buffered words
//   overflow                 sticky: completion dropped while full
//   proto_err                sticky: illegal APB sequence observed
//   drop_cnt                 dropped completions, saturating at 255

module apb_rsp_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              psel1,
    input  logic              psel2,
    input  logic              psel3,
    input  logic              psel4,
    input  logic              penable,
    input  logic              pwrite,
    input  logic              pready,
    input  logic [3:0]        paddr,
    input  logic [15:0]       pwdata,
    input  logic [15:0]       prdata,
    input  logic              log_writes,
    input  logic              m_ready,
    input  logic              clr_err,
    output logic              m_valid,
    output logic [21:0]       m_data,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              proto_err,
    output logic [7:0]        drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [21:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic                r_proto_err;
    logic [7:0]          r_drop_cnt;

    logic                w_any_sel;
    logic [2:0]          w_sel_cnt;
    logic                w_one_sel;
    logic                w_multi_sel;
    logic [1:0]          w_slave_idx;
    logic                w_in_xfer;
    logic                w_complete;
    logic                w_proto_bad;
    logic                w_push_req;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [21:0]         w_word;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_any_sel   = psel1 | psel2 | psel3 | psel4;
    assign w_sel_cnt   = 3'(psel1) + 3'(psel2) + 3'(psel3) + 3'(psel4);
    assign w_one_sel   = (w_sel_cnt == 3'd1);
    assign w_multi_sel = (w_sel_cnt > 3'd1);

    // Only meaningful when exactly one select is high.
    always_comb begin
        w_slave_idx = 2'd0;
        if (psel2) w_slave_idx = 2'd1;
        if (psel3) w_slave_idx = 2'd2;
        if (psel4) w_slave_idx = 2'd3;
    end

    // ------------------------------------------------------------------
    // Phase tracker
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_any_sel) begin
            w_state_nxt = penable ? ST_ACCESS : ST_SETUP;
        end
    end

    // A completion must follow a setup (or a wait-stated access); an
    // access straight out of IDLE is a protocol error, never a capture.
    assign w_in_xfer   = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign w_complete  = w_one_sel & penable & pready & w_in_xfer;

    assign w_proto_bad = w_multi_sel
                       | (penable & w_any_sel & (r_state == ST_IDLE))
                       | (penable & ~w_any_sel);

    assign w_push_req  = w_complete & (~pwrite | log_writes);
    assign w_word      = {paddr, (pwrite ? pwdata : prdata), w_slave_idx};

    // ------------------------------------------------------------------
    // Buffer control
    // ------------------------------------------------------------------
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = (r_count != '0) & m_ready;
    // A pop in the same cycle frees the slot, so a push while full is
    // still accepted when the head is leaving.
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & w_full & ~w_pop;

    always_ff @(posedge pclk) begin
        if (prst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error reporting; a clear wins over a same-cycle set.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (clr_err) begin
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_proto_bad) begin
                r_proto_err <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_valid   = (r_count != '0);
    assign m_data    = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign proto_err = r_proto_err;
    assign drop_cnt  = r_drop_cnt;

endmodule
